// File: rtl/axi_ram_ctrl.sv
// axi_ram_ctrl: AXI4 slave bridging write/read bursts onto a single-port word RAM.
// Optional byte-strobe read-modify-write merge is enabled by defining AXI_RAM_WSTRB_RMW_EN.
module axi_ram_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int RAM_DEPTH  = 256
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,

    input  logic [ID_WIDTH-1:0]     i_awid,
    input  logic [ADDR_WIDTH-1:0]   i_awaddr,
    input  logic [7:0]              i_awlen,
    input  logic [1:0]              i_awburst,
    input  logic                    i_awvalid,
    output logic                    o_awready,

    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_wstrb,
    input  logic                    i_wlast,
    input  logic                    i_wvalid,
    output logic                    o_wready,

    output logic [ID_WIDTH-1:0]     o_bid,
    output logic [1:0]              o_bresp,
    output logic                    o_bvalid,
    input  logic                    i_bready,

    input  logic [ID_WIDTH-1:0]     i_arid,
    input  logic [ADDR_WIDTH-1:0]   i_araddr,
    input  logic [7:0]              i_arlen,
    input  logic [1:0]              i_arburst,
    input  logic                    i_arvalid,
    output logic                    o_arready,

    output logic [ID_WIDTH-1:0]     o_rid,
    output logic [DATA_WIDTH-1:0]   o_rdata,
    output logic [1:0]              o_rresp,
    output logic                    o_rlast,
    output logic                    o_rvalid,
    input  logic                    i_rready,

    output logic                    o_ram_en,
    output logic                    o_ram_we,
    output logic [ADDR_WIDTH-1:0]   o_ram_addr,
    output logic [DATA_WIDTH-1:0]   o_ram_wdata,
    input  logic [DATA_WIDTH-1:0]   i_ram_rdata
);

    localparam int              IW          = ADDR_WIDTH - 2;
    localparam int              NB          = DATA_WIDTH / 8;
    localparam logic [IW-1:0]   DEPTH_IDX   = IW'(RAM_DEPTH);
    localparam logic [1:0]      BURST_FIXED = 2'b00;
    localparam logic [1:0]      RESP_OKAY   = 2'b00;
    localparam logic [1:0]      RESP_SLVERR = 2'b10;

    // IDLE: arbitrate AW/AR, WDATA: accept W beats, WRESP: hold B, RDATA: stream R beats
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WDATA = 2'd1,
        S_WRESP = 2'd2,
        S_RDATA = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_prio_rd;
    logic [ID_WIDTH-1:0]    r_id;
    logic [IW-1:0]          r_idx;
    logic [7:0]             r_len;
    logic [7:0]             r_cnt;
    logic [1:0]             r_burst;
    logic                   r_err;

    logic                   w_sel_w;
    logic                   w_sel_r;
    logic                   w_in_range;
    logic                   w_last_beat;
    logic                   w_bad_burst;
    logic                   w_wbeat_err;
    logic [IW-1:0]          w_idx_nxt;
    logic [DATA_WIDTH-1:0]  w_wdata_eff;
    logic                   w_unused;

    // Ties go to whichever channel r_prio_rd names; a lone requester always wins.
    assign w_sel_w     = i_awvalid & (~i_arvalid | ~r_prio_rd);
    assign w_sel_r     = i_arvalid & (~i_awvalid |  r_prio_rd);

    assign w_in_range  = (r_idx < DEPTH_IDX);
    assign w_last_beat = (r_cnt == r_len);
    assign w_bad_burst = r_burst[1];
    assign w_idx_nxt   = (r_burst == BURST_FIXED) ? r_idx : r_idx + IW'(1);
    assign w_wbeat_err = w_bad_burst | ~w_in_range | (i_wlast != w_last_beat);

    assign o_ram_addr  = {2'b00, r_idx};
    assign o_bid       = r_id;
    assign o_rid       = r_id;

`ifdef AXI_RAM_WSTRB_RMW_EN
    // Merge uses the same-cycle combinational read of the addressed word.
    always_comb begin
        w_wdata_eff = i_wdata;
        for (int i = 0; i < NB; i++) begin
            if (!i_wstrb[i]) begin
                w_wdata_eff[8*i +: 8] = i_ram_rdata[8*i +: 8];
            end
        end
    end
    assign w_unused = ^{i_awaddr[1:0], i_araddr[1:0]};
`else
    assign w_wdata_eff = i_wdata;
    assign w_unused    = ^{i_awaddr[1:0], i_araddr[1:0], i_wstrb};
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_prio_rd <= 1'b0;
            r_id      <= '0;
            r_idx     <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_burst   <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_sel_w || w_sel_r) begin
                        r_prio_rd <= ~r_prio_rd;
                        r_cnt     <= '0;
                        r_err     <= 1'b0;
                        if (w_sel_w) begin
                            r_id    <= i_awid;
                            r_idx   <= i_awaddr[ADDR_WIDTH-1:2];
                            r_len   <= i_awlen;
                            r_burst <= i_awburst;
                        end else begin
                            r_id    <= i_arid;
                            r_idx   <= i_araddr[ADDR_WIDTH-1:2];
                            r_len   <= i_arlen;
                            r_burst <= i_arburst;
                        end
                    end
                end
                S_WDATA: begin
                    if (i_wvalid) begin
                        r_cnt <= r_cnt + 8'd1;
                        r_idx <= w_idx_nxt;
                        r_err <= r_err | w_wbeat_err;
                    end
                end
                S_RDATA: begin
                    if (i_rready) begin
                        r_cnt <= r_cnt + 8'd1;
                        r_idx <= w_idx_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_awready   = 1'b0;
        o_arready   = 1'b0;
        o_wready    = 1'b0;
        o_bvalid    = 1'b0;
        o_bresp     = RESP_OKAY;
        o_rvalid    = 1'b0;
        o_rresp     = RESP_OKAY;
        o_rlast     = 1'b0;
        o_rdata     = '0;
        o_ram_en    = 1'b0;
        o_ram_we    = 1'b0;
        o_ram_wdata = '0;

        case (r_state)
            S_IDLE: begin
                o_awready = w_sel_w;
                o_arready = w_sel_r;
                if (w_sel_w) begin
                    w_state_nxt = S_WDATA;
                end else if (w_sel_r) begin
                    w_state_nxt = S_RDATA;
                end
            end
            S_WDATA: begin
                o_wready = 1'b1;
                if (i_wvalid) begin
                    // Out-of-range beats are consumed but never reach the RAM.
                    if (w_in_range) begin
                        o_ram_en    = 1'b1;
                        o_ram_we    = 1'b1;
                        o_ram_wdata = w_wdata_eff;
                    end
                    if (w_last_beat) begin
                        w_state_nxt = S_WRESP;
                    end
                end
            end
            S_WRESP: begin
                o_bvalid = 1'b1;
                o_bresp  = r_err ? RESP_SLVERR : RESP_OKAY;
                if (i_bready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RDATA: begin
                o_rvalid = 1'b1;
                o_ram_en = w_in_range;
                o_rdata  = w_in_range ? i_ram_rdata : '0;
                o_rresp  = (w_bad_burst || !w_in_range) ? RESP_SLVERR : RESP_OKAY;
                o_rlast  = w_last_beat;
                if (i_rready && w_last_beat) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_axi_ram_ctrl.sv
// tb_axi_ram_ctrl: directed vector table, hand sequences and random bursts against a word-level model.
module tb_axi_ram_ctrl;

    logic        clk;
    logic        rst_n;
    logic [3:0]  awid, arid, bid, rid;
    logic [31:0] awaddr, araddr;
    logic [7:0]  awlen, arlen;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awvalid, awready, arvalid, arready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic        bvalid, bready;
    logic        rlast, rvalid, rready;
    logic        ram_en, ram_we;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic        load_ram;
    logic [31:0] ram     [0:255];
    logic [31:0] ref_mem [0:255];

    axi_ram_ctrl dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_awid     (awid),
        .i_awaddr   (awaddr),
        .i_awlen    (awlen),
        .i_awburst  (awburst),
        .i_awvalid  (awvalid),
        .o_awready  (awready),
        .i_wdata    (wdata),
        .i_wstrb    (wstrb),
        .i_wlast    (wlast),
        .i_wvalid   (wvalid),
        .o_wready   (wready),
        .o_bid      (bid),
        .o_bresp    (bresp),
        .o_bvalid   (bvalid),
        .i_bready   (bready),
        .i_arid     (arid),
        .i_araddr   (araddr),
        .i_arlen    (arlen),
        .i_arburst  (arburst),
        .i_arvalid  (arvalid),
        .o_arready  (arready),
        .o_rid      (rid),
        .o_rdata    (rdata),
        .o_rresp    (rresp),
        .o_rlast    (rlast),
        .o_rvalid   (rvalid),
        .i_rready   (rready),
        .o_ram_en   (ram_en),
        .o_ram_we   (ram_we),
        .o_ram_addr (ram_addr),
        .o_ram_wdata(ram_wdata),
        .i_ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input int i);
        return (32'(i) * 32'h9E3779B9) ^ 32'hA5A5_0000;
    endfunction

    // Physical RAM: synchronous write, combinational read.
    always @(posedge clk) begin
        if (load_ram) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
        end else if (ram_en && ram_we && ram_addr < 32'd256) begin
            ram[ram_addr[7:0]] <= ram_wdata;
        end
    end
    assign ram_rdata = (ram_addr < 32'd256) ? ram[ram_addr[7:0]] : 32'h0;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic tmo(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting, expected handshake", name);
    endtask

    // ---------------- word-level reference model ----------------
    function automatic logic [29:0] beat_word(input logic [31:0] addr, input logic [1:0] burst, input int k);
        return addr[31:2] + ((burst == 2'b00) ? 30'd0 : 30'(k));
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] strb);
        logic [31:0] m;
        m = nw;
`ifdef AXI_RAM_WSTRB_RMW_EN
        for (int b = 0; b < 4; b++) if (!strb[b]) m[8*b +: 8] = old[8*b +: 8];
`else
        if (strb == 4'hF && old == 32'h0) m = nw;
`endif
        return m;
    endfunction

    function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                                               input logic [31:0] d0, input logic [3:0] strb, input bit bad_last);
        bit err;
        logic [29:0] ix;
        err = burst[1] || bad_last;
        for (int k = 0; k <= int'(len); k++) begin
            ix = beat_word(addr, burst, k);
            if (ix < 30'd256) ref_mem[ix[7:0]] = merge(ref_mem[ix[7:0]], d0 + 32'(k), strb);
            else err = 1'b1;
        end
        return err ? 2'b10 : 2'b00;
    endfunction

    task automatic mem_check(input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < 256; i++) if (ram[i] !== ref_mem[i]) bad++;
        chk(name, 32'(bad), 32'd0);
    endtask

    // ---------------- bus tasks ----------------
    task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input logic [31:0] d0, input logic [3:0] strb,
                             input bit bad_last, input bit rnd,
                             output logic [1:0] resp, output logic [1:0] exp_resp);
        int n;
        resp = 2'b11;
        exp_resp = 2'b00;
        @(negedge clk);
        awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
        #1;
        n = 0;
        while (!awready) begin
            n++;
            if (n > 20) begin tmo("aw_handshake"); awvalid = 1'b0; return; end
            @(negedge clk); #1;
        end
        @(negedge clk);
        awvalid = 1'b0;
        for (int k = 0; k <= int'(len); k++) begin
            if (rnd && $urandom_range(0, 3) == 0) begin wvalid = 1'b0; @(negedge clk); end
            wdata  = d0 + 32'(k);
            wstrb  = strb;
            wlast  = (k == int'(len)) ^ (bad_last && k == 0);
            wvalid = 1'b1;
            #1;
            n = 0;
            while (!wready) begin
                n++;
                if (n > 20) begin tmo("w_handshake"); wvalid = 1'b0; return; end
                @(negedge clk); #1;
            end
            @(negedge clk);
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        #1;
        chk("bvalid_next_cycle", bvalid, 1'b1);
        n = 0;
        while (!bvalid) begin
            n++;
            if (n > 20) begin tmo("b_wait"); return; end
            @(negedge clk); #1;
        end
        repeat (rnd ? $urandom_range(0, 2) : 0) begin
            @(negedge clk); #1;
            chk("bvalid_held", bvalid, 1'b1);
        end
        chk("bid", bid, id);
        resp  = bresp;
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        #1;
        chk("bvalid_drop", bvalid, 1'b0);
        exp_resp = model_write(addr, len, burst, d0, strb, bad_last);
    endtask

    task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input int stall_at, input bit rnd,
                            output logic [1:0] agg, output logic [1:0] exp_agg, output logic [31:0] first);
        int n, stalls;
        logic [29:0] ix;
        logic [31:0] exp_d;
        logic [1:0]  exp_r;
        agg = 2'b00; exp_agg = 2'b00; first = 32'hX;
        @(negedge clk);
        arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
        #1;
        n = 0;
        while (!arready) begin
            n++;
            if (n > 20) begin tmo("ar_handshake"); arvalid = 1'b0; return; end
            @(negedge clk); #1;
        end
        @(negedge clk);
        arvalid = 1'b0;
        #1;
        for (int k = 0; k <= int'(len); k++) begin
            ix    = beat_word(addr, burst, k);
            exp_d = (ix < 30'd256) ? ref_mem[ix[7:0]] : 32'h0;
            exp_r = (burst[1] || ix >= 30'd256) ? 2'b10 : 2'b00;
            chk("rvalid", rvalid, 1'b1);
            chk("rdata", rdata, exp_d);
            chk("rresp", rresp, exp_r);
            chk("rlast", rlast, (k == int'(len)));
            chk("rid", rid, id);
            if (k == 0) first = rdata;
            agg     = agg | rresp;
            exp_agg = exp_agg | exp_r;
            stalls = (k == stall_at) ? 3 : (rnd ? $urandom_range(0, 2) : 0);
            repeat (stalls) begin
                @(negedge clk); #1;
                chk("rdata_stall", rdata, exp_d);
                chk("rlast_stall", rlast, (k == int'(len)));
            end
            rready = 1'b1;
            @(negedge clk);
            rready = 1'b0;
            #1;
        end
        chk("rvalid_drop", rvalid, 1'b0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          wr;
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [1:0]  burst;
        logic [31:0] d0;
        logic [3:0]  strb;
        bit          bad_last;
        int          stall_at;
        bit          chk_d0;
        logic [1:0]  exp_resp;
    } vec_t;

    function automatic vec_t mk(input bit wr, input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                                input logic [1:0] burst, input logic [31:0] d0, input logic [3:0] strb,
                                input bit bad_last, input int stall_at, input bit chk_d0, input logic [1:0] exp_resp);
        vec_t v;
        v.wr = wr; v.id = id; v.addr = addr; v.len = len; v.burst = burst; v.d0 = d0; v.strb = strb;
        v.bad_last = bad_last; v.stall_at = stall_at; v.chk_d0 = chk_d0; v.exp_resp = exp_resp;
        return v;
    endfunction

    vec_t vecs[$];

    initial begin
        logic [1:0]  resp, exp_resp;
        logic [31:0] first;
        logic [31:0] strb_exp;
        int          n;

`ifdef AXI_RAM_WSTRB_RMW_EN
        strb_exp = 32'h11BB33DD;
`else
        strb_exp = 32'hAABBCCDD;
`endif
        //               wr id  addr          len  bst d0            strb   bad stall chk exp
        vecs.push_back(mk(1, 1, 32'h10,       0,   1,  32'hDEADBEEF, 4'hF,  0,  -1,   0,  2'b00));
        vecs.push_back(mk(0, 2, 32'h10,       0,   1,  32'hDEADBEEF, 4'hF,  0,  -1,   1,  2'b00));
        vecs.push_back(mk(1, 3, 32'h40,       3,   1,  32'h1,        4'hF,  0,  -1,   0,  2'b00));
        vecs.push_back(mk(0, 4, 32'h40,       3,   1,  32'h1,        4'hF,  0,   2,   1,  2'b00));
        vecs.push_back(mk(1, 5, 32'h20,       2,   0,  32'hA,        4'hF,  0,  -1,   0,  2'b00));
        vecs.push_back(mk(0, 6, 32'h20,       0,   1,  32'hC,        4'hF,  0,  -1,   1,  2'b00));
        vecs.push_back(mk(0, 7, 32'h400,      0,   1,  32'h0,        4'hF,  0,  -1,   1,  2'b10));
        vecs.push_back(mk(1, 8, 32'h400,      0,   1,  32'h77777777, 4'hF,  0,  -1,   0,  2'b10));
        vecs.push_back(mk(1, 9, 32'h3F8,      3,   1,  32'h900,      4'hF,  0,  -1,   0,  2'b10));
        vecs.push_back(mk(0, 10, 32'h3F8,     3,   1,  32'h900,      4'hF,  0,   1,   1,  2'b10));
        vecs.push_back(mk(1, 11, 32'h60,      1,   2,  32'h600,      4'hF,  0,  -1,   0,  2'b10));
        vecs.push_back(mk(0, 12, 32'h60,      1,   2,  32'h600,      4'hF,  0,  -1,   1,  2'b10));
        vecs.push_back(mk(1, 13, 32'h80,      1,   1,  32'h800,      4'hF,  1,  -1,   0,  2'b10));
        vecs.push_back(mk(0, 14, 32'h80,      1,   1,  32'h800,      4'hF,  0,  -1,   1,  2'b00));
        vecs.push_back(mk(1, 15, 32'hFFFFFFFC, 1,  1,  32'hF00,      4'hF,  0,  -1,   0,  2'b10));
        vecs.push_back(mk(0, 0, 32'h0,        0,   1,  32'hF01,      4'hF,  0,  -1,   1,  2'b00));
        vecs.push_back(mk(1, 1, 32'h90,       0,   1,  32'h11223344, 4'hF,  0,  -1,   0,  2'b00));
        vecs.push_back(mk(1, 2, 32'h90,       0,   1,  32'hAABBCCDD, 4'h5,  0,  -1,   0,  2'b00));
        vecs.push_back(mk(0, 3, 32'h90,       0,   1,  strb_exp,     4'hF,  0,  -1,   1,  2'b00));
        vecs.push_back(mk(1, 4, 32'h0,        255, 1,  32'h1000,     4'hF,  0,  -1,   0,  2'b00));
        vecs.push_back(mk(0, 5, 32'h0,        255, 1,  32'h1000,     4'hF,  0, 100,   1,  2'b00));
        vecs.push_back(mk(0, 6, 32'h3,        1,   3,  32'h1000,     4'hF,  0,  -1,   1,  2'b10));

        rst_n = 1'b0; load_ram = 1'b1;
        awid = '0; awaddr = '0; awlen = '0; awburst = '0; awvalid = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arburst = '0; arvalid = 1'b0;
        wdata = '0; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0; rready = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        repeat (2) @(negedge clk);
        load_ram = 1'b0;
        #1;
        chk("rst_awready", awready, 1'b0);
        chk("rst_arready", arready, 1'b0);
        chk("rst_wready", wready, 1'b0);
        chk("rst_bvalid", bvalid, 1'b0);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_bresp", bresp, 2'b00);
        chk("rst_rresp", rresp, 2'b00);
        chk("rst_bid", bid, 4'h0);
        chk("rst_rid", rid, 4'h0);
        chk("rst_ram_en", ram_en, 1'b0);
        chk("rst_ram_we", ram_we, 1'b0);
        chk("rst_ram_wdata", ram_wdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_check("mem_after_reset");

        // Simultaneous AW/AR straight out of reset: write first, then read.
        @(negedge clk);
        awid = 4'd3; awaddr = 32'h80; awlen = 8'd0; awburst = 2'b01; awvalid = 1'b1;
        arid = 4'd5; araddr = 32'h80; arlen = 8'd0; arburst = 2'b01; arvalid = 1'b1;
        #1;
        chk("tie1_awready", awready, 1'b1);
        chk("tie1_arready", arready, 1'b0);
        @(negedge clk);
        awvalid = 1'b0; wdata = 32'h12345678; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
        #1;
        chk("tie1_arready_busy", arready, 1'b0);
        chk("tie1_wready", wready, 1'b1);
        @(negedge clk);
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
        #1;
        chk("tie1_bvalid", bvalid, 1'b1);
        chk("tie1_bid", bid, 4'd3);
        @(negedge clk);
        bready = 1'b0;
        resp = model_write(32'h80, 8'd0, 2'b01, 32'h12345678, 4'hF, 1'b0);
        awid = 4'd6; awaddr = 32'h84; awlen = 8'd0; awburst = 2'b01; awvalid = 1'b1;
        #1;
        chk("tie2_arready", arready, 1'b1);
        chk("tie2_awready", awready, 1'b0);
        @(negedge clk);
        arvalid = 1'b0; rready = 1'b1;
        #1;
        chk("tie2_rvalid", rvalid, 1'b1);
        chk("tie2_rdata", rdata, 32'h12345678);
        chk("tie2_rid", rid, 4'd5);
        @(negedge clk);
        rready = 1'b0;
        #1;
        chk("tie3_awready", awready, 1'b1);
        @(negedge clk);
        awvalid = 1'b0; wdata = 32'h0BADF00D; wlast = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
        #1;
        chk("tie3_bvalid", bvalid, 1'b1);
        chk("tie3_bid", bid, 4'd6);
        @(negedge clk);
        bready = 1'b0;
        resp = model_write(32'h84, 8'd0, 2'b01, 32'h0BADF00D, 4'hF, 1'b0);
        mem_check("mem_tie");

        foreach (vecs[i]) begin
            if (vecs[i].wr) begin
                axi_write(vecs[i].id, vecs[i].addr, vecs[i].len, vecs[i].burst, vecs[i].d0, vecs[i].strb,
                          vecs[i].bad_last, 1'b0, resp, exp_resp);
                chk("vec_bresp", resp, vecs[i].exp_resp);
                mem_check("vec_mem");
            end else begin
                axi_read(vecs[i].id, vecs[i].addr, vecs[i].len, vecs[i].burst, vecs[i].stall_at, 1'b0,
                         resp, exp_resp, first);
                chk("vec_rresp", resp, vecs[i].exp_resp);
                if (vecs[i].chk_d0) chk("vec_rdata0", first, vecs[i].d0);
            end
        end

        for (int t = 0; t < 40; t++) begin
            logic [31:0] a;
            logic [7:0]  l;
            logic [1:0]  b;
            a = 32'($urandom_range(0, 300)) * 32'd4 + 32'($urandom_range(0, 3));
            l = 8'($urandom_range(0, 7));
            b = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                axi_write(4'($urandom), a, l, b, $urandom, 4'($urandom), ($urandom_range(0, 9) == 0), 1'b1,
                          resp, exp_resp);
                chk("rnd_bresp", resp, exp_resp);
                mem_check("rnd_mem");
            end else begin
                axi_read(4'($urandom), a, l, b, -1, 1'b1, resp, exp_resp, first);
                chk("rnd_rresp", resp, exp_resp);
            end
        end

        // Reset in the middle of a 4-beat write after two beats have landed.
        @(negedge clk);
        awid = 4'd9; awaddr = 32'h100; awlen = 8'd3; awburst = 2'b01; awvalid = 1'b1;
        #1;
        n = 0;
        while (!awready && n < 20) begin n++; @(negedge clk); #1; end
        chk("rstmid_awready", awready, 1'b1);
        @(negedge clk);
        awvalid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            wdata = 32'h5000 + 32'(k); wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
            @(negedge clk);
        end
        wdata = 32'h5002;
        rst_n = 1'b0;
        #1;
        chk("rstmid_wready", wready, 1'b0);
        chk("rstmid_awready0", awready, 1'b0);
        chk("rstmid_arready", arready, 1'b0);
        chk("rstmid_bvalid", bvalid, 1'b0);
        chk("rstmid_rvalid", rvalid, 1'b0);
        chk("rstmid_ram_en", ram_en, 1'b0);
        @(negedge clk);
        wvalid = 1'b0;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk); #1;
            chk("rstmid_no_b", bvalid, 1'b0);
        end
        resp = model_write(32'h100, 8'd1, 2'b01, 32'h5000, 4'hF, 1'b0);
        mem_check("rstmid_mem");
        axi_write(4'd10, 32'h100, 8'd3, 2'b01, 32'h6000, 4'hF, 1'b0, 1'b0, resp, exp_resp);
        chk("post_rst_bresp", resp, 2'b00);
        axi_read(4'd11, 32'h100, 8'd3, 2'b01, -1, 1'b0, resp, exp_resp, first);
        chk("post_rst_rresp", resp, 2'b00);
        chk("post_rst_rdata0", first, 32'h6000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
